// File: rtl/move_resolver.sv
// Move resolver: table lookup of damage/accuracy, LFSR accuracy roll, saturating HP update.
// Optional critical hits (double damage on crit_roll == 0) are enabled by defining MOVE_RESOLVER_CRIT_EN.
module move_resolver #(
  parameter int               MOVE_BITS = 2,
  parameter int               DMG_W     = 4,
  parameter int               ACC_W     = 4,
  parameter int               HP_W      = 8,
  parameter int               HP_MAX    = 100,
  parameter logic [(2**MOVE_BITS)*DMG_W-1:0] DMG_TABLE = {4'd10, 4'd7, 4'd5, 4'd3},
  parameter logic [(2**MOVE_BITS)*ACC_W-1:0] ACC_TABLE = {4'd7, 4'd9, 4'd12, 4'd15},
  parameter logic [15:0]      LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MOVE_BITS-1:0] move,
  input  logic                 hp_load,
  input  logic [HP_W-1:0]      hp_init,
  output logic                 busy,
  output logic                 done,
  output logic                 hit,
  output logic                 crit,
  output logic [HP_W-1:0]      dmg_dealt,
  output logic [HP_W-1:0]      hp,
  output logic                 fainted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_ROLL   = 3'd2,
    S_APPLY  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  state_t                 state_q, state_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [MOVE_BITS-1:0]   move_q, move_d;
  logic [DMG_W-1:0]       dmg_q, dmg_d;
  logic [ACC_W-1:0]       accu_q, accu_d;
  logic [ACC_W-1:0]       roll_q, roll_d;
  logic                   hit_n_q, hit_n_d;
  logic [HP_W-1:0]        dealt_n_q, dealt_n_d;
  logic [HP_W-1:0]        hp_q, hp_d;
  logic                   fainted_q, fainted_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   hit_q, hit_d;
  logic [HP_W-1:0]        dmg_dealt_q, dmg_dealt_d;
  logic [HP_W-1:0]        eff_s;
  logic [HP_W-1:0]        dealt_s;
  int                     tbl_idx_s;
`ifdef MOVE_RESOLVER_CRIT_EN
  logic [3:0]             crit_roll_q, crit_roll_d;
  logic                   crit_n_q, crit_n_d;
  logic                   crit_q, crit_d;
  logic [DMG_W:0]         dbl_s;
`endif

  assign tbl_idx_s = int'(move_q);

  // Effective damage and the amount actually removed, clipped so HP never wraps.
  always_comb begin
`ifdef MOVE_RESOLVER_CRIT_EN
    dbl_s = {dmg_q, 1'b0};
    if (!hit_n_q) begin
      eff_s = {HP_W{1'b0}};
    end else if (crit_n_q) begin
      eff_s = HP_W'(dbl_s);
    end else begin
      eff_s = HP_W'(dmg_q);
    end
`else
    if (hit_n_q) begin
      eff_s = HP_W'(dmg_q);
    end else begin
      eff_s = {HP_W{1'b0}};
    end
`endif
    if (eff_s > hp_q) begin
      dealt_s = hp_q;
    end else begin
      dealt_s = eff_s;
    end
  end

  // Next-state and next-output logic for the resolution sequence.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_next(lfsr_q);
    move_d      = move_q;
    dmg_d       = dmg_q;
    accu_d      = accu_q;
    roll_d      = roll_q;
    hit_n_d     = hit_n_q;
    dealt_n_d   = dealt_n_q;
    hp_d        = hp_q;
    fainted_d   = fainted_q;
    hit_d       = hit_q;
    dmg_dealt_d = dmg_dealt_q;
`ifdef MOVE_RESOLVER_CRIT_EN
    crit_roll_d = crit_roll_q;
    crit_n_d    = crit_n_q;
    crit_d      = crit_q;
`endif
    case (state_q)
      S_IDLE: begin
        // hp_load has priority; a start in the same cycle is dropped.
        if (hp_load) begin
          hp_d      = hp_init;
          fainted_d = (hp_init == {HP_W{1'b0}});
        end else if (start && !fainted_q) begin
          move_d  = move;
          state_d = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        dmg_d   = DMG_TABLE[tbl_idx_s*DMG_W +: DMG_W];
        accu_d  = ACC_TABLE[tbl_idx_s*ACC_W +: ACC_W];
        roll_d  = lfsr_q[ACC_W-1:0];
`ifdef MOVE_RESOLVER_CRIT_EN
        crit_roll_d = lfsr_q[7:4];
`endif
        state_d = S_ROLL;
      end
      S_ROLL: begin
        hit_n_d = (roll_q <= accu_q);
`ifdef MOVE_RESOLVER_CRIT_EN
        crit_n_d = (roll_q <= accu_q) && (crit_roll_q == 4'b0000);
`endif
        state_d = S_APPLY;
      end
      S_APPLY: begin
        dealt_n_d = dealt_s;
        hp_d      = hp_q - dealt_s;
        fainted_d = (hp_q == dealt_s);
        state_d   = S_DONE;
      end
      S_DONE: begin
        hit_d       = hit_n_q;
        dmg_dealt_d = dealt_n_q;
`ifdef MOVE_RESOLVER_CRIT_EN
        crit_d      = crit_n_q;
`endif
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  // State and output registers; reset aborts any in-flight resolution.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      move_q      <= {MOVE_BITS{1'b0}};
      dmg_q       <= {DMG_W{1'b0}};
      accu_q      <= {ACC_W{1'b0}};
      roll_q      <= {ACC_W{1'b0}};
      hit_n_q     <= 1'b0;
      dealt_n_q   <= {HP_W{1'b0}};
      hp_q        <= HP_W'(HP_MAX);
      fainted_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      dmg_dealt_q <= {HP_W{1'b0}};
`ifdef MOVE_RESOLVER_CRIT_EN
      crit_roll_q <= 4'b0000;
      crit_n_q    <= 1'b0;
      crit_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      move_q      <= move_d;
      dmg_q       <= dmg_d;
      accu_q      <= accu_d;
      roll_q      <= roll_d;
      hit_n_q     <= hit_n_d;
      dealt_n_q   <= dealt_n_d;
      hp_q        <= hp_d;
      fainted_q   <= fainted_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      dmg_dealt_q <= dmg_dealt_d;
`ifdef MOVE_RESOLVER_CRIT_EN
      crit_roll_q <= crit_roll_d;
      crit_n_q    <= crit_n_d;
      crit_q      <= crit_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hit       = hit_q;
  assign dmg_dealt = dmg_dealt_q;
  assign hp        = hp_q;
  assign fainted   = fainted_q;
`ifdef MOVE_RESOLVER_CRIT_EN
  assign crit      = crit_q;
`else
  assign crit      = 1'b0;
`endif

endmodule

// File: tb/tb_move_resolver.sv
// Directed bench for move_resolver with an independent LFSR reference to predict hits.
module tb_move_resolver;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] move;
  logic       hp_load;
  logic [7:0] hp_init;
  logic       busy, done, hit, crit, fainted;
  logic [7:0] dmg_dealt, hp;

  int n_vec = 0;
  int n_err = 0;
  int exp_hp;
  logic [15:0] m_lfsr;

  move_resolver dut (
    .clk(clk), .reset(reset), .start(start), .move(move),
    .hp_load(hp_load), .hp_init(hp_init), .busy(busy), .done(done),
    .hit(hit), .crit(crit), .dmg_dealt(dmg_dealt), .hp(hp), .fainted(fainted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic int dmg_of(input logic [1:0] mv);
    case (mv)
      2'd0: return 3;
      2'd1: return 5;
      2'd2: return 7;
      default: return 10;
    endcase
  endfunction

  function automatic int acc_of(input logic [1:0] mv);
    case (mv)
      2'd0: return 15;
      2'd1: return 12;
      2'd2: return 9;
      default: return 7;
    endcase
  endfunction

  // Reference LFSR, advancing in lock-step with the design.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic load_hp(input logic [7:0] v);
    hp_load = 1'b1;
    hp_init = v;
    @(negedge clk);
    hp_load = 1'b0;
    hp_init = 8'd0;
  endtask

  // Issues one start at the current negedge and observes 6 cycles; predicts hit/crit from the model.
  task automatic run_move(input logic [1:0] mv, output int busy_cnt, output int done_cnt,
                          output int done_at, output logic o_hit, output logic o_crit,
                          output logic [7:0] o_dealt, output logic [7:0] o_hp,
                          output logic o_fainted, output logic p_hit, output logic p_crit);
    logic [15:0] nx;
    nx = lfsr_step(m_lfsr);
    p_hit = (int'(nx[3:0]) <= acc_of(mv));
`ifdef MOVE_RESOLVER_CRIT_EN
    p_crit = p_hit && (nx[7:4] == 4'b0000);
`else
    p_crit = 1'b0;
`endif
    start = 1'b1;
    move = mv;
    busy_cnt = 0;
    done_cnt = 0;
    done_at = -1;
    o_hit = 1'b0; o_crit = 1'b0; o_dealt = 8'd0; o_hp = 8'd0; o_fainted = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
      end
      if (i == 4) begin
        o_hit = hit; o_crit = crit; o_dealt = dmg_dealt; o_hp = hp; o_fainted = fainted;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; hp_load = 1'b0; move = 2'd0; hp_init = 8'd0;
    repeat (2) @(negedge clk);
    n_vec++; if (hp !== 8'd100) begin n_err++; $display("FAIL reset_hp: got %0d want 100", hp); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b want 0", hit); end
    n_vec++; if (crit !== 1'b0) begin n_err++; $display("FAIL reset_crit: got %b want 0", crit); end
    n_vec++; if (dmg_dealt !== 8'd0) begin n_err++; $display("FAIL reset_dealt: got %0d want 0", dmg_dealt); end
    n_vec++; if (fainted !== 1'b0) begin n_err++; $display("FAIL reset_fainted: got %b want 0", fainted); end
    reset = 1'b0;
    n_vec++; if (dut.lfsr_q !== 16'hACE1) begin n_err++; $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr_q); end
    @(negedge clk);
    n_vec++; if (dut.lfsr_q !== lfsr_step(16'hACE1)) begin
      n_err++; $display("FAIL lfsr_step: got %h want %h", dut.lfsr_q, lfsr_step(16'hACE1));
    end
    exp_hp = 100;
  endtask

  task automatic test_basic();
    int bc, dc, da;
    logic oh, oc, of, ph, pc;
    logic [7:0] od, ohp;
    load_hp(8'd50);
    run_move(2'd0, bc, dc, da, oh, oc, od, ohp, of, ph, pc);
    n_vec++; if (bc != 4) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
    n_vec++; if (dc != 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", dc); end
    n_vec++; if (da != 4) begin n_err++; $display("FAIL basic_done_cycle: got %0d want 4", da); end
    n_vec++; if (oh !== 1'b1) begin n_err++; $display("FAIL basic_hit: got %b want 1", oh); end
    n_vec++; if (od !== 8'd3) begin n_err++; $display("FAIL basic_dealt: got %0d want 3", od); end
    n_vec++; if (ohp !== 8'd47) begin n_err++; $display("FAIL basic_hp: got %0d want 47", ohp); end
    n_vec++; if (of !== 1'b0) begin n_err++; $display("FAIL basic_fainted: got %b want 0", of); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got %b want 0", done); end
    exp_hp = 47;
  endtask

  task automatic test_faint();
    int bc, dc, da;
    logic oh, oc, of, ph, pc;
    logic [7:0] od, ohp;
    bit got = 1'b0;
    load_hp(8'd2);
    for (int k = 0; k < 64 && !got; k++) begin
      run_move(2'd3, bc, dc, da, oh, oc, od, ohp, of, ph, pc);
      n_vec++; if (oh !== ph) begin n_err++; $display("FAIL faint_hit: got %b want %b", oh, ph); end
      if (ph) begin
        got = 1'b1;
        n_vec++; if (od !== 8'd2) begin n_err++; $display("FAIL faint_dealt: got %0d want 2", od); end
        n_vec++; if (ohp !== 8'd0) begin n_err++; $display("FAIL faint_hp: got %0d want 0", ohp); end
        n_vec++; if (of !== 1'b1) begin n_err++; $display("FAIL faint_flag: got %b want 1", of); end
      end else begin
        n_vec++; if (od !== 8'd0 || ohp !== 8'd2) begin
          n_err++; $display("FAIL faint_miss: got dealt %0d hp %0d want 0 and 2", od, ohp);
        end
      end
    end
    if (!got) begin
      n_vec++; n_err++; $display("FAIL faint_timeout: got no predicted hit want one within 64 tries");
    end
    for (int k = 0; k < 2; k++) begin
      run_move(2'd3, bc, dc, da, oh, oc, od, ohp, of, ph, pc);
      n_vec++; if (bc != 0 || dc != 0) begin
        n_err++; $display("FAIL fainted_ignore: got busy %0d done %0d want 0 and 0", bc, dc);
      end
      n_vec++; if (hp !== 8'd0) begin n_err++; $display("FAIL fainted_hp: got %0d want 0", hp); end
    end
  endtask

  task automatic test_busy_ignore();
    int dcnt = 0;
    int bcnt = 0;
    load_hp(8'd60);
    start = 1'b1; move = 2'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; move = 2'd1; hp_load = 1'b1; hp_init = 8'd5;
    @(negedge clk);
    start = 1'b0; hp_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    n_vec++; if (dcnt != 1) begin n_err++; $display("FAIL busy_done_count: got %0d want 1", dcnt); end
    n_vec++; if (hp !== 8'd57) begin n_err++; $display("FAIL busy_hp: got %0d want 57", hp); end
    n_vec++; if (dmg_dealt !== 8'd3) begin n_err++; $display("FAIL busy_dealt: got %0d want 3", dmg_dealt); end
    start = 1'b1; hp_load = 1'b1; hp_init = 8'd20; move = 2'd1;
    @(negedge clk);
    start = 1'b0; hp_load = 1'b0;
    n_vec++; if (hp !== 8'd20) begin n_err++; $display("FAIL simul_hp: got %0d want 20", hp); end
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    n_vec++; if (dcnt != 0 || bcnt != 0) begin
      n_err++; $display("FAIL simul_no_start: got done %0d busy %0d want 0 and 0", dcnt, bcnt);
    end
    exp_hp = 20;
  endtask

  task automatic test_stats();
    int bc, dc, da, exp_d, eff;
    int hits_o = 0;
    int hits_p = 0;
    logic oh, oc, of, ph, pc;
    logic [7:0] od, ohp;
    for (int k = 0; k < 1024; k++) begin
      if (exp_hp < 20) begin
        load_hp(8'd200);
        exp_hp = 200;
      end
      run_move(2'd3, bc, dc, da, oh, oc, od, ohp, of, ph, pc);
      eff = ph ? (pc ? 20 : 10) : 0;
      exp_d = (eff > exp_hp) ? exp_hp : eff;
      if (oh === 1'b1) hits_o++;
      if (ph) hits_p++;
      n_vec++; if (dc != 1 || oh !== ph || oc !== pc) begin
        n_err++; $display("FAIL stats_roll %0d: got done %0d hit %b crit %b want 1 %b %b", k, dc, oh, oc, ph, pc);
      end
      n_vec++; if (od !== 8'(exp_d) || ohp !== 8'(exp_hp - exp_d)) begin
        n_err++; $display("FAIL stats_hp %0d: got dealt %0d hp %0d want %0d %0d", k, od, ohp, exp_d, exp_hp - exp_d);
      end
      exp_hp = exp_hp - exp_d;
    end
    n_vec++; if (hits_o != hits_p) begin n_err++; $display("FAIL stats_hits: got %0d want %0d", hits_o, hits_p); end
    n_vec++; if (hits_o < 448 || hits_o > 576) begin
      n_err++; $display("FAIL stats_range: got %0d want 448..576", hits_o);
    end
  endtask

`ifdef MOVE_RESOLVER_CRIT_EN
  task automatic test_crit();
    int bc, dc, da;
    logic oh, oc, of, ph, pc;
    logic [7:0] od, ohp;
    logic [15:0] nx;
    bit found = 1'b0;
    load_hp(8'd200);
    for (int k = 0; k < 4000 && !found; k++) begin
      nx = lfsr_step(m_lfsr);
      if (nx[3:0] <= 4'd7 && nx[7:4] == 4'd0) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) begin
      n_vec++; n_err++; $display("FAIL crit_timeout: got no crit window want one within 4000 cycles");
    end else begin
      run_move(2'd3, bc, dc, da, oh, oc, od, ohp, of, ph, pc);
      n_vec++; if (oc !== 1'b1) begin n_err++; $display("FAIL crit_flag: got %b want 1", oc); end
      n_vec++; if (od !== 8'd20) begin n_err++; $display("FAIL crit_dealt: got %0d want 20", od); end
      n_vec++; if (ohp !== 8'd180) begin n_err++; $display("FAIL crit_hp: got %0d want 180", ohp); end
    end
  endtask
`endif

  task automatic test_reset_apply();
    int dcnt = 0;
    bit found = 1'b0;
    logic [15:0] nx;
    load_hp(8'd50);
    for (int k = 0; k < 64 && !found; k++) begin
      nx = lfsr_step(m_lfsr);
      if (nx[3:0] <= 4'd9) found = 1'b1;
      else @(negedge clk);
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL rst_window: got none want a hit window"); end
    start = 1'b1; move = 2'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    n_vec++; if (dcnt != 0) begin n_err++; $display("FAIL rst_apply_done: got %0d want 0", dcnt); end
    n_vec++; if (hp !== 8'd100) begin n_err++; $display("FAIL rst_apply_hp: got %0d want 100", hp); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_apply_busy: got %b want 0", busy); end
    n_vec++; if (dut.state_q !== 3'd0) begin n_err++; $display("FAIL rst_apply_state: got %0d want 0", dut.state_q); end
    exp_hp = 100;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_faint();
    test_busy_ignore();
    test_stats();
`ifdef MOVE_RESOLVER_CRIT_EN
    test_crit();
`endif
    test_reset_apply();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
